// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits, odd parity, stop, ACK check.
// Optional macro PS2_TX_GLITCH_FILTER_EN requires 8 stable high then 8 stable low cycles per clock fall.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       RX_INHIBIT,
    input  logic       PS2CLK_IN,
    input  logic       PS2DATA_IN,
    output logic       PS2CLK_OE,
    output logic       PS2DATA_OE
);

    localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                          : TIMEOUT_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_fall;
    logic [8:0]             shift;
    logic [3:0]             bitcnt;
    logic [TW-1:0]          timer;
    logic                   ack_err;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic                   clk_oe;
    logic                   data_oe;

    // Pin synchronizers; idle bus level is high
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2CLK_IN};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2DATA_IN};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [14:0] clk_hist;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) clk_hist <= '1;
        else        clk_hist <= {clk_hist[13:0], clk_s};
    end

    // Oldest 8 samples high, newest 8 low: one qualified fall
    assign clk_fall = ({clk_hist, clk_s} == 16'hFF00);
`else
    logic clk_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) clk_prev <= 1'b1;
        else        clk_prev <= clk_s;
    end

    assign clk_fall = clk_prev & ~clk_s;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            shift   <= '0;
            bitcnt  <= '0;
            timer   <= '0;
            ack_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // A start coinciding with the end-of-frame pulse is dropped
                S_IDLE: begin
                    if (TX_START && !done && !err) begin
                        shift   <= {~^TX_DATA, TX_DATA};
                        bitcnt  <= '0;
                        timer   <= '0;
                        ack_err <= 1'b0;
                        busy    <= 1'b1;
                        clk_oe  <= 1'b1;
                        state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        data_oe <= 1'b1;
                        state   <= S_REQ;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_REQ: begin
                    clk_oe <= 1'b0;
                    timer  <= '0;
                    state  <= S_SEND;
                end
                S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
                    // Timeout takes priority over any edge seen this cycle
                    if (timer == TIMEOUT_LAST) begin
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                        if (state == S_SEND) begin
                            if (clk_fall) begin
                                if (bitcnt == 4'd9) begin
                                    data_oe <= 1'b0;
                                    state   <= S_WAIT_ACK;
                                end else begin
                                    data_oe <= ~shift[0];
                                    shift   <= {1'b0, shift[8:1]};
                                    bitcnt  <= bitcnt + 4'd1;
                                end
                            end
                        end else if (state == S_WAIT_ACK) begin
                            if (clk_fall) begin
                                ack_err <= data_s;
                                state   <= S_WAIT_IDLE;
                            end
                        end else if (clk_s && data_s) begin
                            busy  <= 1'b0;
                            done  <= ~ack_err;
                            err   <= ack_err;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY       = busy;
    assign DONE       = done;
    assign ERR        = err;
    assign RX_INHIBIT = busy;
    assign PS2CLK_OE  = clk_oe;
    assign PS2DATA_OE = data_oe;

endmodule
